dec_trigger_csr: RTL
====================

DEC_TRIGGER_CSR -- requirements
Module: dec_trigger_csr

Interface
REQ-001 SHALL have parameter NUM_TRIG, default 4, giving the number of triggers; only the value 4 is supported.
REQ-002 SHALL have parameter TSELECT_ADDR, default 12'h7A0, giving the tselect CSR address; tdata1 SHALL be TSELECT_ADDR+1 and tdata2 SHALL be TSELECT_ADDR+2.
REQ-003 clk  in  1  single clock for all flops.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 csr_wen  in  1  CSR write strobe.
REQ-006 csr_waddr  in  12  write address.
REQ-007 csr_wdata  in  32  write data.
REQ-008 csr_raddr  in  12  read address.
REQ-009 csr_rdata  out  32  read data, combinational.
REQ-010 csr_rhit  out  1  csr_raddr decodes to one of the three trigger CSRs.
REQ-011 debug_mode  in  1  core is in debug mode.
REQ-012 raw_hit_wb  in  4  per-trigger match of the retiring instruction, unchained.
REQ-013 raw_hit_valid_wb  in  1  qualifies raw_hit_wb.
REQ-014 trigger_pkt_any  out  4 x trigger_pkt_t  fields select, match, store, load, execute, m, tdata2[31:0]; drives the decode and LSU matchers.
REQ-015 trig_fire  out  4  registered per-trigger fire after chaining.
REQ-016 trig_dbg_req  out  1  fired trigger requests debug entry (action=1).
REQ-017 trig_bkpt_req  out  1  fired trigger requests a breakpoint exception (action=0).

Function
REQ-018 tselect SHALL be 2 bits; reads SHALL return it zero-extended; a write of a value >3 SHALL be ignored.
REQ-019 Per trigger, tdata1 SHALL store dmode[27], hit[20], select[19], action[12] (one bit), chain[11], match[7] (0 = equal, 1 = NAPOT mask), m[6], execute[2], store[1] and load[0].
REQ-020 tdata1 reads SHALL return type[31:28]=2 and maskmax[26:21]=31; all unimplemented bits SHALL read 0.
REQ-021 Writes to tdata1/tdata2 SHALL target the trigger indexed by tselect.
REQ-022 A write to a trigger whose dmode=1 SHALL be dropped when debug_mode=0.
REQ-023 The dmode bit SHALL be writable only when debug_mode=1; otherwise it SHALL keep its value.
REQ-024 A written action=1 with a resulting dmode=0 SHALL store action=0.
REQ-025 chain SHALL be writable only on triggers 0 and 2; on triggers 1 and 3 it SHALL read 0.
REQ-026 trigger_pkt_any SHALL be driven directly from flops, so a CSR write is visible on the next cycle (latency 1); execute/store/load SHALL be gated by m.
REQ-027 Chain pairs SHALL be (0,1) and (2,3): when chain[2k]=1, both members of pair k SHALL fire only if raw_hit_wb[2k] and raw_hit_wb[2k+1] are both set; otherwise each trigger SHALL fire on its own raw hit.
REQ-028 The fire vector SHALL require raw_hit_valid_wb=1 and SHALL register into trig_fire one cycle later.
REQ-029 trig_dbg_req / trig_bkpt_req SHALL be the OR over fired triggers with action=1 / action=0, registered in the same cycle as trig_fire.
REQ-030 A fired trigger SHALL set its hit bit at the same edge as trig_fire.
REQ-031 hit SHALL clear only by a CSR write.
REQ-032 When a CSR write to a trigger's tdata1 and a hit set for that trigger occur in the same cycle, the CSR write SHALL win.
REQ-033 A debug_mode=1 cycle SHALL suppress fire: trig_fire and the request outputs SHALL be 0 and hit bits SHALL not be set.

Reset
REQ-034 rst SHALL clear tselect, every tdata1 field, every tdata2, trig_fire, trig_dbg_req and trig_bkpt_req to 0; all trigger_pkt_any enables SHALL therefore be 0.
REQ-035 rst asserted mid-operation SHALL force the reset values immediately, and a fire pending in that cycle SHALL be discarded.

Structure
REQ-036 trigger_pkt_t, the CSR address constants and the tdata1 bit-position constants SHALL live in swerv_types.
REQ-037 A per-trigger sub-module dec_trigger_reg SHALL hold one tdata1/tdata2 pair plus its write-qualify logic, instantiated 4 times.

Verification
REQ-038 Reset, then read tdata1 of trigger 0 -> 32'h23E0_0000; trigger_pkt_any execute is all 0.
REQ-039 tselect=1; tdata1=32'h0000_0044; tdata2=32'h0000_1000 -> next cycle trigger_pkt_any[1] has execute=1, tdata2=32'h1000; raw_hit_wb=4'b0010 with valid -> trig_fire=4'b0010 one cycle later, trig_bkpt_req=1, tdata1[20]=1.
REQ-040 Chain: trigger 0 with chain=1, both 0 and 1 execute -> raw_hit_wb=4'b0001 gives trig_fire=0; raw_hit_wb=4'b0011 gives trig_fire=4'b0011.
REQ-041 debug_mode=0, write tdata1=32'h0800_1044 -> dmode=0 and action=0 stored; with debug_mode=1 the same write stores dmode=1, action=1; afterwards a debug_mode=0 write is dropped.
REQ-042 Same-cycle tdata1 write of 0 and raw hit on the selected trigger -> hit reads 0 and trig_fire is still asserted.
REQ-043 tselect write of 5 -> tselect unchanged; rst asserted during a fire cycle -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/swerv_types.sv
// Shared types and constants for the debug trigger CSR block.
//   trigger_pkt_t : per-trigger match configuration sent to decode/LSU matchers
//   td1_t         : the writable/stored fields of one tdata1 register
//   csr_sel_e     : which trigger CSR (if any) an address selects
package swerv_types;

  localparam logic [11:0] CSR_TSELECT = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

  localparam int TD1_TYPE_LSB    = 28;
  localparam int TD1_DMODE       = 27;
  localparam int TD1_MASKMAX_LSB = 21;
  localparam int TD1_HIT         = 20;
  localparam int TD1_SELECT      = 19;
  localparam int TD1_ACTION      = 12;
  localparam int TD1_CHAIN       = 11;
  localparam int TD1_MATCH       = 7;
  localparam int TD1_M           = 6;
  localparam int TD1_EXECUTE     = 2;
  localparam int TD1_STORE       = 1;
  localparam int TD1_LOAD        = 0;

  localparam logic [3:0] TD1_TYPE_VAL    = 4'd2;
  localparam logic [5:0] TD1_MASKMAX_VAL = 6'd31;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } td1_t;

  typedef enum logic [1:0] {
    CSR_NONE,
    CSR_TSEL,
    CSR_TD1,
    CSR_TD2
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(logic [11:0] addr, logic [11:0] base);
    csr_sel_e sel;
    sel = CSR_NONE;
    if (addr == base)               sel = CSR_TSEL;
    else if (addr == base + 12'd1)  sel = CSR_TD1;
    else if (addr == base + 12'd2)  sel = CSR_TD2;
    return sel;
  endfunction

  // Architectural tdata1 view: constant type/maskmax, stored fields, zeros elsewhere.
  function automatic logic [31:0] td1_read(td1_t t);
    logic [31:0] v;
    v = '0;
    v[TD1_TYPE_LSB +: 4]    = TD1_TYPE_VAL;
    v[TD1_DMODE]            = t.dmode;
    v[TD1_MASKMAX_LSB +: 6] = TD1_MASKMAX_VAL;
    v[TD1_HIT]              = t.hit;
    v[TD1_SELECT]           = t.select;
    v[TD1_ACTION]           = t.action;
    v[TD1_CHAIN]            = t.chain;
    v[TD1_MATCH]            = t.match;
    v[TD1_M]                = t.m;
    v[TD1_EXECUTE]          = t.execute;
    v[TD1_STORE]            = t.store;
    v[TD1_LOAD]             = t.load;
    return v;
  endfunction

endpackage

// File: rtl/dec_trigger_reg.sv
// One trigger's tdata1/tdata2 storage with write qualification.
//   i_wen_tdata1/2 : write strobes already steered to this trigger
//   i_wf           : tdata1 fields of the write data
//   i_wdata        : full write data (tdata2)
//   i_debug_mode   : core in debug mode (gates dmode-owned writes)
//   i_hit_set      : this trigger fired this cycle
//   o_td1/o_tdata2 : stored state; o_pkt : matcher configuration
module dec_trigger_reg
  import swerv_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wen_tdata1,
  input  logic         i_wen_tdata2,
  input  td1_t         i_wf,
  input  logic [31:0]  i_wdata,
  input  logic         i_debug_mode,
  input  logic         i_hit_set,
  output td1_t         o_td1,
  output logic [31:0]  o_tdata2,
  output trigger_pkt_t o_pkt
);

  td1_t        r_td1;
  logic [31:0] r_tdata2;
  logic        w_wr_ok;
  logic        w_dmode;
  td1_t        w_td1_wr;

  // A debugger-owned trigger is read-only to machine-mode software.
  assign w_wr_ok = !(r_td1.dmode && !i_debug_mode);
  assign w_dmode = i_debug_mode ? i_wf.dmode : r_td1.dmode;

  always_comb begin
    w_td1_wr        = i_wf;
    w_td1_wr.dmode  = w_dmode;
    // Entering debug mode is only legal for debugger-owned triggers.
    w_td1_wr.action = i_wf.action & w_dmode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_td1    <= '0;
      r_tdata2 <= '0;
    end else begin
      // A same-cycle CSR write overrides the hit set by a fire.
      if (i_wen_tdata1 && w_wr_ok) r_td1 <= w_td1_wr;
      else if (i_hit_set)          r_td1.hit <= 1'b1;
      if (i_wen_tdata2 && w_wr_ok) r_tdata2 <= i_wdata;
    end
  end

  assign o_td1          = r_td1;
  assign o_tdata2       = r_tdata2;
  assign o_pkt.select   = r_td1.select;
  assign o_pkt.match    = r_td1.match;
  assign o_pkt.m        = r_td1.m;
  assign o_pkt.execute  = r_td1.execute & r_td1.m;
  assign o_pkt.store    = r_td1.store & r_td1.m;
  assign o_pkt.load     = r_td1.load & r_td1.m;
  assign o_pkt.tdata2   = r_tdata2;

endmodule

// File: rtl/dec_trigger_csr.sv
// Debug trigger CSRs (tselect/tdata1/tdata2), chaining and fire registration.
//   csr_*            : CSR write port and combinational read port
//   debug_mode       : suppresses firing while in debug mode
//   raw_hit_wb/valid : unchained per-trigger matches of the retiring instruction
//   trigger_pkt_any  : per-trigger matcher configuration (from flops)
//   trig_fire        : registered chained fire vector
//   trig_dbg_req / trig_bkpt_req : fired trigger wants debug entry / breakpoint
module dec_trigger_csr
  import swerv_types::*;
#(
  parameter int          NUM_TRIG     = 4,
  parameter logic [11:0] TSELECT_ADDR = CSR_TSELECT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        csr_wen,
  input  logic [11:0]                 csr_waddr,
  input  logic [31:0]                 csr_wdata,
  input  logic [11:0]                 csr_raddr,
  output logic [31:0]                 csr_rdata,
  output logic                        csr_rhit,
  input  logic                        debug_mode,
  input  logic [NUM_TRIG-1:0]         raw_hit_wb,
  input  logic                        raw_hit_valid_wb,
  output trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  output logic [NUM_TRIG-1:0]         trig_fire,
  output logic                        trig_dbg_req,
  output logic                        trig_bkpt_req
);

  logic [1:0]          r_tselect;
  logic [NUM_TRIG-1:0] r_fire;
  logic                r_dbg_req;
  logic                r_bkpt_req;

  csr_sel_e            w_wsel;
  csr_sel_e            w_rsel;
  td1_t                w_wf;
  td1_t                w_td1 [NUM_TRIG];
  logic [31:0]         w_td2 [NUM_TRIG];
  logic [NUM_TRIG-1:0] w_sel_oh;
  logic [NUM_TRIG-1:0] w_raw;
  logic [NUM_TRIG-1:0] w_fire;
  logic [NUM_TRIG-1:0] w_action;

  assign w_wsel = csr_wen ? csr_decode(csr_waddr, TSELECT_ADDR) : CSR_NONE;
  assign w_rsel = csr_decode(csr_raddr, TSELECT_ADDR);

  always_comb begin
    w_wf         = '0;
    w_wf.dmode   = csr_wdata[TD1_DMODE];
    w_wf.hit     = csr_wdata[TD1_HIT];
    w_wf.select  = csr_wdata[TD1_SELECT];
    w_wf.action  = csr_wdata[TD1_ACTION];
    w_wf.chain   = csr_wdata[TD1_CHAIN];
    w_wf.match   = csr_wdata[TD1_MATCH];
    w_wf.m       = csr_wdata[TD1_M];
    w_wf.execute = csr_wdata[TD1_EXECUTE];
    w_wf.store   = csr_wdata[TD1_STORE];
    w_wf.load    = csr_wdata[TD1_LOAD];
  end

  always_comb begin
    w_sel_oh            = '0;
    w_sel_oh[r_tselect] = 1'b1;
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    // Only the even trigger of each pair carries a chain bit.
    localparam bit CHAIN_OK = (g % 2) == 0;
    td1_t w_wf_g;

    always_comb begin
      w_wf_g       = w_wf;
      w_wf_g.chain = w_wf.chain & CHAIN_OK;
    end

    dec_trigger_reg u_reg (
      .clk          (clk),
      .rst          (rst),
      .i_wen_tdata1 ((w_wsel == CSR_TD1) && w_sel_oh[g]),
      .i_wen_tdata2 ((w_wsel == CSR_TD2) && w_sel_oh[g]),
      .i_wf         (w_wf_g),
      .i_wdata      (csr_wdata),
      .i_debug_mode (debug_mode),
      .i_hit_set    (w_fire[g]),
      .o_td1        (w_td1[g]),
      .o_tdata2     (w_td2[g]),
      .o_pkt        (trigger_pkt_any[g])
    );

    assign w_action[g] = w_td1[g].action;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tselect <= '0;
    else if ((w_wsel == CSR_TSEL) && (csr_wdata[31:2] == '0))
      r_tselect <= csr_wdata[1:0];
  end

  always_comb begin
    w_raw  = raw_hit_wb & {NUM_TRIG{raw_hit_valid_wb & ~debug_mode}};
    w_fire = w_raw;
    for (int k = 0; k < NUM_TRIG / 2; k++) begin
      if (w_td1[2*k].chain) begin
        w_fire[2*k]   = w_raw[2*k] & w_raw[2*k+1];
        w_fire[2*k+1] = w_raw[2*k] & w_raw[2*k+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fire     <= '0;
      r_dbg_req  <= 1'b0;
      r_bkpt_req <= 1'b0;
    end else begin
      r_fire     <= w_fire;
      r_dbg_req  <= |(w_fire & w_action);
      r_bkpt_req <= |(w_fire & ~w_action);
    end
  end

  assign trig_fire     = r_fire;
  assign trig_dbg_req  = r_dbg_req;
  assign trig_bkpt_req = r_bkpt_req;

  always_comb begin
    csr_rdata = '0;
    csr_rhit  = (w_rsel != CSR_NONE);
    case (w_rsel)
      CSR_TSEL: csr_rdata = {30'b0, r_tselect};
      CSR_TD1:  csr_rdata = td1_read(w_td1[r_tselect]);
      CSR_TD2:  csr_rdata = w_td2[r_tselect];
      default:  csr_rdata = '0;
    endcase
  end

endmodule
